// File: rtl/matrix_mem_pkg.sv
// mm_pkg: shared definitions for the matrix_mem slice.
//   - default base addresses of the A, B and C regions
//   - region_t: result of the address decode
//   - idx_width(): bits needed to index an N*N element region
package mm_pkg;

    localparam int unsigned A_BASE_DEF = 32'h0200;
    localparam int unsigned B_BASE_DEF = 32'h0300;
    localparam int unsigned C_BASE_DEF = 32'h0100;

    typedef enum logic [1:0] {
        REG_A    = 2'd0,
        REG_B    = 2'd1,
        REG_C    = 2'd2,
        REG_NONE = 2'd3
    } region_t;

    // Never returns 0 so a single-element region still gets a 1-bit index.
    function automatic int idx_width(input int num_elem);
        return (num_elem > 1) ? $clog2(num_elem) : 1;
    endfunction

endpackage

// File: rtl/matrix_mem_if.sv
// matrix_mem_if: request/response bus of matrix_mem.
//   master : drives req_valid/req_we/req_addr/req_wdata and rsp_ready
//   slave  : drives req_ready and rsp_valid/rsp_rdata/rsp_err
interface matrix_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 17
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/matrix_mem_decode.sv
// mm_region_decode: combinational byte-address decode.
//   addr   in  : byte address
//   region out : REG_A/REG_B/REG_C, REG_NONE whenever err is set
//   index  out : element index within the region
//   err    out : misaligned, unmapped page, or index beyond N*N
module mm_region_decode
    import mm_pkg::*;
#(
    parameter int          ADDR_W = 17,
    parameter int          N      = 3,
    parameter int unsigned A_BASE = A_BASE_DEF,
    parameter int unsigned B_BASE = B_BASE_DEF,
    parameter int unsigned C_BASE = C_BASE_DEF,
    localparam int         IDX_W  = idx_width(N * N)
) (
    input  logic [ADDR_W-1:0] addr,
    output region_t           region,
    output logic [IDX_W-1:0]  index,
    output logic              err
);

    localparam logic [ADDR_W-9:0] A_PAGE = (ADDR_W-8)'(A_BASE >> 8);
    localparam logic [ADDR_W-9:0] B_PAGE = (ADDR_W-8)'(B_BASE >> 8);
    localparam logic [ADDR_W-9:0] C_PAGE = (ADDR_W-8)'(C_BASE >> 8);

    region_t page_region;
    logic    out_of_range;

    always_comb begin
        page_region = REG_NONE;
        if (addr[ADDR_W-1:8] == A_PAGE) begin
            page_region = REG_A;
        end else if (addr[ADDR_W-1:8] == B_PAGE) begin
            page_region = REG_B;
        end else if (addr[ADDR_W-1:8] == C_PAGE) begin
            page_region = REG_C;
        end

        // Compare at 32 bits so N*N = 64 does not wrap a 6-bit constant.
        out_of_range = 32'(addr[7:2]) >= 32'(N * N);
        err          = (addr[1:0] != 2'b00) || (page_region == REG_NONE) || out_of_range;
        region       = err ? REG_NONE : page_region;
        index        = addr[2 +: IDX_W];
    end

endmodule

// File: rtl/matrix_mem.sv
// matrix_mem: three N*N word regions (A, B, C) behind a valid/ready
// request bus with a single registered response slot.
//   clk       in  : rising-edge clock
//   rst_n     in  : synchronous active-low reset
//   bus       slv : request/response bus (matrix_mem_if.slave)
//   c_clear   in  : zero matrix C and its written-mask at the next edge
//   c_done    out : every C element written since last clear/reset
//   c_flat    out : C contents, element k at [k*DATA_W +: DATA_W]
module matrix_mem
    import mm_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 17,
    parameter int          N      = 3,
    parameter int unsigned A_BASE = A_BASE_DEF,
    parameter int unsigned B_BASE = B_BASE_DEF,
    parameter int unsigned C_BASE = C_BASE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    matrix_mem_if.slave              bus,
    input  logic                     c_clear,
    output logic                     c_done,
    output logic [N*N*DATA_W-1:0]    c_flat
);

    localparam int NE    = N * N;
    localparam int IDX_W = idx_width(NE);

    logic [DATA_W-1:0] mem_a [NE];
    logic [DATA_W-1:0] mem_b [NE];
    logic [DATA_W-1:0] mem_c [NE];
    logic [NE-1:0]     mask;
    logic [NE-1:0]     mask_next;

    region_t           dec_region;
    logic [IDX_W-1:0]  dec_index;
    logic              dec_err;

    logic              accept;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_data;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    mm_region_decode #(
        .ADDR_W (ADDR_W),
        .N      (N),
        .A_BASE (A_BASE),
        .B_BASE (B_BASE),
        .C_BASE (C_BASE)
    ) u_decode (
        .addr   (bus.req_addr),
        .region (dec_region),
        .index  (dec_index),
        .err    (dec_err)
    );

    // A new request is taken only when the response slot is free or being
    // drained this cycle; a clear cycle blocks requests so C never sees a
    // write and a clear on the same edge.
    assign bus.req_ready = !c_clear && (!rsp_valid_q || bus.rsp_ready);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        accept    = bus.req_valid && bus.req_ready;
        wr_ok     = accept && bus.req_we && !dec_err;
        rd_data   = '0;
        case (dec_region)
            REG_A:   rd_data = mem_a[dec_index];
            REG_B:   rd_data = mem_b[dec_index];
            REG_C:   rd_data = mem_c[dec_index];
            default: rd_data = '0;
        endcase
        mask_next = mask;
        if (wr_ok && dec_region == REG_C) begin
            mask_next[dec_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NE; k++) begin
                mem_a[k] <= '0;
                mem_b[k] <= '0;
                mem_c[k] <= '0;
            end
        end else begin
            if (wr_ok) begin
                case (dec_region)
                    REG_A:   mem_a[dec_index] <= bus.req_wdata;
                    REG_B:   mem_b[dec_index] <= bus.req_wdata;
                    REG_C:   mem_c[dec_index] <= bus.req_wdata;
                    default: ;
                endcase
            end
            if (c_clear) begin
                for (int k = 0; k < NE; k++) begin
                    mem_c[k] <= '0;
                end
            end
        end
    end

    // c_done follows mask_next so it rises in the cycle right after the
    // final missing element commits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask        <= '0;
            c_done      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (c_clear) begin
                mask   <= '0;
                c_done <= 1'b0;
            end else begin
                mask   <= mask_next;
                c_done <= &mask_next;
            end

            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= dec_err;
                rsp_rdata_q <= (bus.req_we || dec_err) ? '0 : rd_data;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NE; k++) begin : g_flat
        assign c_flat[k*DATA_W +: DATA_W] = mem_c[k];
    end

endmodule

// File: doc/matrix_mem.md
MATRIX_MEM -- requirements
Module: matrix_mem

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter ADDR_W, default 17, byte address width.
REQ-003 Parameter N, default 3, matrix dimension; N*N SHALL be at most 64.
REQ-004 Parameters A_BASE/B_BASE/C_BASE, defaults 0x0200/0x0300/0x0100, region base addresses, each a multiple of 0x100.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n).
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-010 req_we  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  DATA_W  write data.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-015 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-016 rsp_err  out  1  unmapped or misaligned access.
REQ-017 c_clear  in  1  zero matrix C and its written-mask.
REQ-018 c_done  out  1  every C element written since last clear/reset.
REQ-019 c_flat  out  N*N*DATA_W  C contents, element k at bits [k*DATA_W +: DATA_W], k = row*N+col.

Function
REQ-020 Three regions A, B, C, each N*N words; element k at byte address BASE + 4k.
REQ-021 Decode: addr[1:0]!=0, addr[ADDR_W-1:8] not matching a base, or addr[7:2] >= N*N SHALL be an error.
REQ-022 All three regions SHALL be readable and writable.
REQ-023 req_ready = !c_clear && (!rsp_valid || rsp_ready); one response outstanding at most.
REQ-024 Accepted write SHALL commit at the accepting edge; accepted read SHALL capture data at the accepting edge; the response is valid on the following cycle (latency 1).
REQ-025 Every accepted request, read or write, SHALL produce exactly one response.
REQ-026 Error access: no array change, rsp_err=1, rsp_rdata=0.
REQ-027 Read issued the cycle after a write to the same address SHALL return the new data.
REQ-028 Response SHALL hold stable while rsp_valid && !rsp_ready.
REQ-029 Back-to-back requests SHALL sustain one per cycle when rsp_ready=1.
REQ-030 Each successful C write SHALL set bit k of a N*N written-mask; rewriting element k SHALL not change the mask.
REQ-031 c_done = mask all ones, registered, asserted the cycle after the last missing element's write commits.
REQ-032 c_clear SHALL zero C and the mask at the next edge; a pending response SHALL be unaffected.
REQ-033 c_flat SHALL reflect committed C contents, combinational from storage.

Reset
REQ-034 With rst_n low at an edge: A, B, C and mask cleared to 0; rsp_valid=0, rsp_rdata=0, rsp_err=0, c_done=0.
REQ-035 Reset mid-transaction SHALL drop any pending response; no response is issued afterwards for it.

Structure
REQ-036 Package mm_pkg SHALL hold the default base constants and a region enum {REG_A, REG_B, REG_C, REG_NONE}.
REQ-037 Sub-module mm_region_decode SHALL map req_addr to region, index and error, combinationally.

Verification
REQ-038 Write 1..9 to A (0x200..0x220), read back 0x210 -> rsp_rdata=5, rsp_err=0, one cycle after accept.
REQ-039 Write C elements 0..8 with 7, rewrite element 4 -> c_done rises exactly once after ninth distinct write; c_flat element 4 holds the rewritten value.
REQ-040 Read 0x202 and 0x224 -> rsp_err=1, rsp_rdata=0, arrays unchanged.
REQ-041 Hold rsp_ready=0 three cycles after a read -> req_ready=0, rsp_rdata stable; release -> next request accepted same cycle.
REQ-042 Assert c_clear with req_valid high -> req_ready=0 that cycle; next cycle c_flat=0, c_done=0.
REQ-043 Drop rst_n while rsp_valid=1 -> next cycle rsp_valid=0, all arrays read back 0.
